// File: rtl/tail_lamp_pkg.sv
// Shared encodings for the tail-lamp indicator bus monitor: modes, lamp patterns,
// FSM states and the expected-step tables of each sweep.
package tail_lamp_pkg;

  localparam logic [1:0] MODE_NONE  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_HAZ   = 2'b11;

  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_1   = 3'b001;
  localparam logic [2:0] LAMP_2   = 3'b011;
  localparam logic [2:0] LAMP_3   = 3'b111;

  localparam logic [2:0] PERIOD_SIDE = 3'd4;
  localparam logic [2:0] PERIOD_HAZ  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2,
    ST_HAZ   = 2'd3
  } state_t;

  function automatic logic [2:0] exp_left(input logic [2:0] phase);
    case (phase)
      3'd1:    exp_left = LAMP_1;
      3'd2:    exp_left = LAMP_2;
      3'd3:    exp_left = LAMP_3;
      default: exp_left = LAMP_OFF;
    endcase
  endfunction

  // Hazard sweeps up then back down; the descending 001 is step 5, not a restart.
  function automatic logic [2:0] exp_haz(input logic [2:0] phase);
    case (phase)
      3'd1:    exp_haz = LAMP_1;
      3'd2:    exp_haz = LAMP_2;
      3'd3:    exp_haz = LAMP_3;
      3'd4:    exp_haz = LAMP_2;
      3'd5:    exp_haz = LAMP_1;
      default: exp_haz = LAMP_OFF;
    endcase
  endfunction

  function automatic logic [1:0] lamp_level(input logic [2:0] lamp);
    case (lamp)
      LAMP_1:  lamp_level = 2'd1;
      LAMP_2:  lamp_level = 2'd2;
      LAMP_3:  lamp_level = 2'd3;
      default: lamp_level = 2'd0;
    endcase
  endfunction

  function automatic logic [2:0] next_phase(input logic [2:0] phase, input logic [2:0] period);
    next_phase = (phase == period - 3'd1) ? 3'd0 : phase + 3'd1;
  endfunction

endpackage

// File: rtl/tail_lamp_pattern_classify.sv
// Combinational classification of one left/right lamp sample.
module tail_lamp_pattern_classify
  import tail_lamp_pkg::*;
(
  input  logic [2:0] i_left,
  input  logic [2:0] i_right,
  output logic       o_legal,
  output logic       o_is_dark,
  output logic       o_is_lstart,
  output logic       o_is_rstart,
  output logic       o_is_hstart,
  output logic [1:0] o_left_level,
  output logic [1:0] o_right_level
);

  logic w_left_ok;
  logic w_right_ok;

  always_comb begin
    w_left_ok     = i_left inside {LAMP_OFF, LAMP_1, LAMP_2, LAMP_3};
    w_right_ok    = i_right inside {LAMP_OFF, LAMP_1, LAMP_2, LAMP_3};
    o_legal       = w_left_ok && w_right_ok &&
                    ((i_left == LAMP_OFF) || (i_right == LAMP_OFF) || (i_left == i_right));
    o_is_dark     = (i_left == LAMP_OFF) && (i_right == LAMP_OFF);
    o_is_lstart   = (i_left == LAMP_1) && (i_right == LAMP_OFF);
    o_is_rstart   = (i_left == LAMP_OFF) && (i_right == LAMP_1);
    o_is_hstart   = (i_left == LAMP_1) && (i_right == LAMP_1);
    o_left_level  = lamp_level(i_left);
    o_right_level = lamp_level(i_right);
  end

endmodule

// File: rtl/tail_lamp_monitor.sv
// Tail-lamp bus monitor: locks onto left/right/hazard sweeps, confirms the mode after
// CONFIRM_CYCLES complete sweeps and flags illegal or out-of-order samples.
module tail_lamp_monitor
  import tail_lamp_pkg::*;
#(
  parameter int CONFIRM_CYCLES = 1,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sample_en,
  input  logic [2:0]       i_left_lamp,
  input  logic [2:0]       i_right_lamp,
  output logic [1:0]       o_mode,
  output logic             o_mode_valid,
  output logic [2:0]       o_phase,
  output logic             o_cycle_done,
  output logic             o_seq_error,
  output logic [CNT_W-1:0] o_cycle_count
);

  localparam logic [2:0] CONF = 3'(CONFIRM_CYCLES);

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_phase, w_phase_nxt, w_phase_adv, w_period;
  logic [2:0]       r_confirm, w_confirm_nxt, w_conf_inc;
  logic [1:0]       r_mode, w_mode_nxt;
  logic             r_mode_valid, w_valid_nxt;
  logic             r_cycle_done, w_cd_nxt;
  logic             r_seq_error, w_err_nxt;
  logic [CNT_W-1:0] r_cycle_count, w_count_nxt;

  logic       w_legal, w_is_dark, w_is_lstart, w_is_rstart, w_is_hstart;
  logic [1:0] w_left_level, w_right_level, w_exp_l, w_exp_r;
  logic       w_match, w_start, w_advance, w_clear, w_err;

  function automatic logic [1:0] mode_of(input state_t s);
    case (s)
      ST_LEFT:  mode_of = MODE_LEFT;
      ST_RIGHT: mode_of = MODE_RIGHT;
      ST_HAZ:   mode_of = MODE_HAZ;
      default:  mode_of = MODE_NONE;
    endcase
  endfunction

  tail_lamp_pattern_classify u_classify (
    .i_left        (i_left_lamp),
    .i_right       (i_right_lamp),
    .o_legal       (w_legal),
    .o_is_dark     (w_is_dark),
    .o_is_lstart   (w_is_lstart),
    .o_is_rstart   (w_is_rstart),
    .o_is_hstart   (w_is_hstart),
    .o_left_level  (w_left_level),
    .o_right_level (w_right_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_phase       <= 3'd0;
      r_confirm     <= 3'd0;
      r_mode        <= MODE_NONE;
      r_mode_valid  <= 1'b0;
      r_cycle_done  <= 1'b0;
      r_seq_error   <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase       <= w_phase_nxt;
      r_confirm     <= w_confirm_nxt;
      r_mode        <= w_mode_nxt;
      r_mode_valid  <= w_valid_nxt;
      r_cycle_done  <= w_cd_nxt;
      r_seq_error   <= w_err_nxt;
      r_cycle_count <= w_count_nxt;
    end
  end

  // Compare the sample against the step that should follow the current phase.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_advance   = 1'b0;
    w_clear     = 1'b0;
    w_err       = 1'b0;
    w_period    = (r_state == ST_HAZ) ? PERIOD_HAZ : PERIOD_SIDE;
    w_phase_adv = next_phase(r_phase, w_period);
    w_exp_l     = 2'd0;
    w_exp_r     = 2'd0;
    case (r_state)
      ST_LEFT:  w_exp_l = lamp_level(exp_left(w_phase_adv));
      ST_RIGHT: w_exp_r = lamp_level(exp_left(w_phase_adv));
      ST_HAZ: begin
        w_exp_l = lamp_level(exp_haz(w_phase_adv));
        w_exp_r = w_exp_l;
      end
      default: ;
    endcase
    w_match = w_legal && (w_left_level == w_exp_l) && (w_right_level == w_exp_r);

    if (i_sample_en) begin
      if (r_state == ST_IDLE) begin
        if (!w_legal) begin
          w_err = 1'b1;
        end else if (w_is_lstart) begin
          w_state_nxt = ST_LEFT;
          w_start     = 1'b1;
        end else if (w_is_rstart) begin
          w_state_nxt = ST_RIGHT;
          w_start     = 1'b1;
        end else if (w_is_hstart) begin
          w_state_nxt = ST_HAZ;
          w_start     = 1'b1;
        end
      end else if (w_match) begin
        w_advance = 1'b1;
      end else begin
        // An unexpected dark is a clean stop; anything else is a violation.
        w_state_nxt = ST_IDLE;
        w_clear     = 1'b1;
        w_err       = !w_is_dark;
      end
    end
  end

  always_comb begin
    w_phase_nxt   = r_phase;
    w_confirm_nxt = r_confirm;
    w_mode_nxt    = r_mode;
    w_valid_nxt   = r_mode_valid;
    w_count_nxt   = r_cycle_count;
    w_cd_nxt      = 1'b0;
    w_err_nxt     = w_err;
    w_conf_inc    = (r_confirm == 3'd7) ? r_confirm : r_confirm + 3'd1;
    if (w_clear) begin
      w_phase_nxt   = 3'd0;
      w_confirm_nxt = 3'd0;
      w_mode_nxt    = MODE_NONE;
      w_valid_nxt   = 1'b0;
      w_count_nxt   = '0;
    end else if (w_start) begin
      w_phase_nxt   = 3'd1;
      w_confirm_nxt = 3'd0;
      if (CONF == 3'd0) begin
        w_valid_nxt = 1'b1;
        w_mode_nxt  = mode_of(w_state_nxt);
      end
    end else if (w_advance) begin
      w_phase_nxt = w_phase_adv;
      if (w_phase_adv == 3'd0) begin
        w_confirm_nxt = w_conf_inc;
        if (r_mode_valid || (w_conf_inc == CONF)) begin
          w_valid_nxt = 1'b1;
          w_mode_nxt  = mode_of(r_state);
          w_cd_nxt    = 1'b1;
          w_count_nxt = (&r_cycle_count) ? r_cycle_count : r_cycle_count + 1'b1;
        end
      end
    end
  end

  assign o_mode        = r_mode;
  assign o_mode_valid  = r_mode_valid;
  assign o_phase       = r_phase;
  assign o_cycle_done  = r_cycle_done;
  assign o_seq_error   = r_seq_error;
  assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_tail_lamp_monitor.sv
// Directed, table-driven bench for tail_lamp_monitor (CONFIRM_CYCLES=1 main instance,
// CONFIRM_CYCLES=0 companion instance for the immediate-confirm case).
module tb_tail_lamp_monitor;

  localparam logic [2:0] D  = 3'b000;
  localparam logic [2:0] P1 = 3'b001;
  localparam logic [2:0] P2 = 3'b011;
  localparam logic [2:0] P3 = 3'b111;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [2:0] l;
    logic [2:0] r;
    logic [1:0] mode;
    logic       mv;
    logic [2:0] ph;
    logic       cd;
    logic       er;
    logic [7:0] cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_en = 1'b0;
  logic [2:0] left_lamp = 3'b000;
  logic [2:0] right_lamp = 3'b000;

  logic [1:0] mode1, mode0;
  logic       mv1, mv0, cd1, cd0, er1, er0;
  logic [2:0] ph1, ph0;
  logic [7:0] cnt1, cnt0;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  tail_lamp_monitor #(.CONFIRM_CYCLES(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .i_sample_en(sample_en),
    .i_left_lamp(left_lamp), .i_right_lamp(right_lamp),
    .o_mode(mode1), .o_mode_valid(mv1), .o_phase(ph1),
    .o_cycle_done(cd1), .o_seq_error(er1), .o_cycle_count(cnt1)
  );

  tail_lamp_monitor #(.CONFIRM_CYCLES(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .i_sample_en(sample_en),
    .i_left_lamp(left_lamp), .i_right_lamp(right_lamp),
    .o_mode(mode0), .o_mode_valid(mv0), .o_phase(ph0),
    .o_cycle_done(cd0), .o_seq_error(er0), .o_cycle_count(cnt0)
  );

  function automatic vec_t mk(input logic r_, input logic e, input logic [2:0] l, input logic [2:0] r,
                              input logic [1:0] m, input logic v, input logic [2:0] p,
                              input logic c, input logic x, input logic [7:0] n);
    vec_t t;
    t.rst = r_; t.en = e; t.l = l; t.r = r;
    t.mode = m; t.mv = v; t.ph = p; t.cd = c; t.er = x; t.cnt = n;
    return t;
  endfunction

  task automatic check(input string name, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got mode=%0d valid=%0d phase=%0d done=%0d err=%0d count=%0d, expected mode=%0d valid=%0d phase=%0d done=%0d err=%0d count=%0d",
               name, a[15:14], a[13], a[12:10], a[9], a[8], a[7:0],
               e[15:14], e[13], e[12:10], e[9], e[8], e[7:0]);
    end
  endtask

  task automatic step(input logic r_, input logic e, input logic [2:0] l, input logic [2:0] r);
    rst = r_; sample_en = e; left_lamp = l; right_lamp = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst en  left right   mode  mv ph  cd er cnt
    tbl.push_back(mk(1, 0, D,  D,  2'd0, 0, 0, 0, 0, 0));
    // left sweep twice, confirm after first wrap
    tbl.push_back(mk(0, 1, D,  D,  2'd0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, P1, D,  2'd0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, P2, D,  2'd0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, P3, D,  2'd0, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 1, D,  D,  2'd1, 1, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, P1, D,  2'd1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, P2, D,  2'd1, 1, 2, 0, 0, 1));
    tbl.push_back(mk(0, 1, P3, D,  2'd1, 1, 3, 0, 0, 1));
    tbl.push_back(mk(0, 1, D,  D,  2'd1, 1, 0, 1, 0, 2));
    // second dark ends left mode, then hazard twice
    tbl.push_back(mk(0, 1, D,  D,  2'd0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, P1, P1, 2'd0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, P2, P2, 2'd0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, P3, P3, 2'd0, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 1, P2, P2, 2'd0, 0, 4, 0, 0, 0));
    tbl.push_back(mk(0, 1, P1, P1, 2'd0, 0, 5, 0, 0, 0));
    tbl.push_back(mk(0, 1, D,  D,  2'd3, 1, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, P1, P1, 2'd3, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, P2, P2, 2'd3, 1, 2, 0, 0, 1));
    tbl.push_back(mk(0, 1, P3, P3, 2'd3, 1, 3, 0, 0, 1));
    tbl.push_back(mk(0, 1, P2, P2, 2'd3, 1, 4, 0, 0, 1));
    tbl.push_back(mk(0, 1, P1, P1, 2'd3, 1, 5, 0, 0, 1));
    tbl.push_back(mk(0, 1, D,  D,  2'd3, 1, 0, 1, 0, 2));
    // illegal samples from IDLE, then mid-sweep join ignored
    tbl.push_back(mk(0, 1, D,  D,  2'd0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b010, D, 2'd0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, P1, P2, 2'd0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, P2, D,  2'd0, 0, 0, 0, 0, 0));
    // left locked, skipped step, restart
    tbl.push_back(mk(0, 1, P1, D,  2'd0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, P2, D,  2'd0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, P3, D,  2'd0, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 1, D,  D,  2'd1, 1, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, P1, D,  2'd1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, P3, D,  2'd0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, P1, D,  2'd0, 0, 1, 0, 0, 0));
    // relock left, early dark drops mode cleanly, right sweep confirms
    tbl.push_back(mk(0, 1, P2, D,  2'd0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, P3, D,  2'd0, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 1, D,  D,  2'd1, 1, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, P1, D,  2'd1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, D,  D,  2'd0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, D,  P1, 2'd0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, D,  P2, 2'd0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, D,  P3, 2'd0, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 1, D,  D,  2'd2, 1, 0, 1, 0, 1));
    // disabled edge holds state and clears pulses; wrong side at phase 0
    tbl.push_back(mk(0, 0, D,  D,  2'd2, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, P1, D,  2'd0, 0, 0, 0, 1, 0));
    // hazard with sample_en toggling, then reset mid-sweep
    tbl.push_back(mk(0, 1, P1, P1, 2'd0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, P2, P2, 2'd0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, P2, P2, 2'd0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, P3, P3, 2'd0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, P3, P3, 2'd0, 0, 3, 0, 0, 0));
    tbl.push_back(mk(1, 1, P2, P2, 2'd0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, P2, P2, 2'd0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].l, tbl[i].r);
      check($sformatf("vec%0d", i), {mode1, mv1, ph1, cd1, er1, cnt1},
            {tbl[i].mode, tbl[i].mv, tbl[i].ph, tbl[i].cd, tbl[i].er, tbl[i].cnt});
    end

    // CONFIRM_CYCLES=0 confirms on the first B001; CONFIRM_CYCLES=1 does not
    step(1, 0, D, D);
    step(0, 1, P1, P1);
    check("conf0_first_b001", {mode0, mv0, ph0, cd0, er0, cnt0}, {2'd3, 1'b1, 3'd1, 1'b0, 1'b0, 8'd0});
    check("conf1_first_b001", {mode1, mv1, ph1, cd1, er1, cnt1}, {2'd0, 1'b0, 3'd1, 1'b0, 1'b0, 8'd0});
    step(0, 1, P2, P2);
    step(0, 1, P3, P3);
    step(0, 1, P2, P2);
    step(0, 1, P1, P1);
    step(0, 1, D, D);
    check("conf0_first_wrap", {mode0, mv0, ph0, cd0, er0, cnt0}, {2'd3, 1'b1, 3'd0, 1'b1, 1'b0, 8'd1});

    // cycle_count saturation over many left sweeps
    begin
      int done_seen;
      int err_seen;
      done_seen = 0;
      err_seen = 0;
      step(1, 0, D, D);
      for (int s = 0; s < 260; s++) begin
        step(0, 1, P1, D); done_seen += int'(cd1); err_seen += int'(er1);
        step(0, 1, P2, D); done_seen += int'(cd1); err_seen += int'(er1);
        step(0, 1, P3, D); done_seen += int'(cd1); err_seen += int'(er1);
        step(0, 1, D, D);  done_seen += int'(cd1); err_seen += int'(er1);
      end
      check("sat_state", {mode1, mv1, ph1, cd1, er1, cnt1}, {2'd1, 1'b1, 3'd0, 1'b1, 1'b0, 8'd255});
      check("sat_done_pulses", 16'(done_seen), 16'd260);
      check("sat_no_error", 16'(err_seen), 16'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
